// File: rtl/s3_pkg.sv
// Shared definitions for the S3 wake (exit) sequencer: state encoding,
// retention-RAM context addresses and default timing parameters.
package s3_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SLEEP   = 3'd1,
    ST_PWR_UP  = 3'd2,
    ST_RESTORE = 3'd3,
    ST_ISO_REL = 3'd4,
    ST_RST_REL = 3'd5,
    ST_CLK_EN  = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  localparam logic [1:0] CTX_ADDR_RESULT = 2'd0;
  localparam logic [1:0] CTX_ADDR_A      = 2'd1;
  localparam logic [1:0] CTX_ADDR_B      = 2'd2;
  localparam logic [1:0] CTX_ADDR_OPCODE = 2'd3;

  localparam int unsigned DEF_PWR_SETTLE = 4;
  localparam int unsigned DEF_RST_HOLD   = 2;
  localparam int unsigned DEF_PG_TIMEOUT = 16;

endpackage

// File: rtl/s3_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module s3_cycle_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/s3_wake_sequencer.sv
// S3 exit sequencer: rail on, settle, context restore, isolation/reset release, clock ungate.
// Optional macro RESTORE_TIMEOUT_EN adds a per-word rd_ack timeout in RESTORE.
module s3_wake_sequencer
  import s3_pkg::*;
#(
  parameter int unsigned PWR_SETTLE = DEF_PWR_SETTLE,
  parameter int unsigned RST_HOLD   = DEF_RST_HOLD,
  parameter int unsigned PG_TIMEOUT = DEF_PG_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sleep_entered,
  input  logic       wake_req,
  input  logic       pwr_good,
  output logic       rd_req,
  output logic [1:0] rd_addr,
  input  logic       rd_ack,
  input  logic [3:0] rd_data,
  output logic [3:0] restored_result,
  output logic [3:0] restored_a,
  output logic [3:0] restored_b,
  output logic [1:0] restored_opcode,
  output logic       pwr_on,
  output logic       isolation,
  output logic       reset_assert,
  output logic       clk_gate,
  output logic       wake_done,
  output logic       wake_err,
  output logic [2:0] state
);

  localparam int unsigned TMAX = (PG_TIMEOUT > PWR_SETTLE) ? PG_TIMEOUT : PWR_SETTLE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t        state_q;
  logic          armed;
  logic          ack_ok;
  logic          settle_load, settle_en, settle_done;
  logic          tmo_load, tmo_en, tmo_done;
  logic [TW-1:0] settle_val, tmo_val;

  // First cycle of each word ignores rd_ack, so every word spans at least two cycles.
  assign ack_ok = rd_req & armed & rd_ack;
  assign state  = state_q;

  // Settle timer doubles as the reset-hold timer; timeout timer guards PWR_UP.
  always_comb begin
    settle_load = 1'b0;
    settle_en   = 1'b0;
    settle_val  = '0;
    tmo_load    = 1'b0;
    tmo_en      = 1'b0;
    tmo_val     = '0;
    case (state_q)
      ST_SLEEP: begin
        if (wake_req) begin
          settle_load = 1'b1;
          settle_val  = TW'(PWR_SETTLE);
          tmo_load    = 1'b1;
          tmo_val     = TW'(PG_TIMEOUT);
        end
      end
      ST_PWR_UP: begin
        if (!pwr_good) begin
          settle_load = 1'b1;
          settle_val  = TW'(PWR_SETTLE);
        end else begin
          settle_en = 1'b1;
        end
        tmo_en = 1'b1;
`ifdef RESTORE_TIMEOUT_EN
        if (settle_done) begin
          tmo_load = 1'b1;
          tmo_val  = TW'(PG_TIMEOUT - 1);
        end
`endif
      end
`ifdef RESTORE_TIMEOUT_EN
      ST_RESTORE: begin
        if (ack_ok) begin
          tmo_load = 1'b1;
          tmo_val  = TW'(PG_TIMEOUT - 1);
        end else begin
          tmo_en = 1'b1;
        end
      end
`endif
      ST_ISO_REL: begin
        settle_load = 1'b1;
        settle_val  = TW'(RST_HOLD - 1);
      end
      ST_RST_REL: settle_en = 1'b1;
      default: ;
    endcase
  end

  s3_cycle_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (settle_load),
    .load_val (settle_val),
    .en       (settle_en),
    .done     (settle_done)
  );

  s3_cycle_timer #(.W(TW)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (tmo_val),
    .en       (tmo_en),
    .done     (tmo_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      pwr_on          <= 1'b1;
      isolation       <= 1'b1;
      reset_assert    <= 1'b0;
      clk_gate        <= 1'b0;
      rd_req          <= 1'b0;
      rd_addr         <= CTX_ADDR_RESULT;
      armed           <= 1'b0;
      restored_result <= '0;
      restored_a      <= '0;
      restored_b      <= '0;
      restored_opcode <= '0;
      wake_done       <= 1'b0;
      wake_err        <= 1'b0;
    end else begin
      wake_done <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (sleep_entered) begin
            state_q      <= ST_SLEEP;
            pwr_on       <= 1'b0;
            isolation    <= 1'b0;
            reset_assert <= 1'b1;
            clk_gate     <= 1'b1;
          end
        end
        ST_SLEEP: begin
          if (wake_req) begin
            state_q <= ST_PWR_UP;
            pwr_on  <= 1'b1;
          end
        end
        ST_PWR_UP: begin
          if (settle_done) begin
            state_q <= ST_RESTORE;
            rd_addr <= CTX_ADDR_RESULT;
            rd_req  <= 1'b1;
            armed   <= 1'b0;
          end else if (tmo_done) begin
            state_q  <= ST_ERROR;
            pwr_on   <= 1'b0;
            wake_err <= 1'b1;
          end
        end
        ST_RESTORE: begin
          armed <= 1'b1;
          if (ack_ok) begin
            case (rd_addr)
              CTX_ADDR_RESULT: restored_result <= rd_data;
              CTX_ADDR_A:      restored_a      <= rd_data;
              CTX_ADDR_B:      restored_b      <= rd_data;
              default:         restored_opcode <= rd_data[1:0];
            endcase
            if (rd_addr == CTX_ADDR_OPCODE) begin
              rd_req  <= 1'b0;
              state_q <= ST_ISO_REL;
            end else begin
              rd_addr <= rd_addr + 2'd1;
              armed   <= 1'b0;
            end
          end
`ifdef RESTORE_TIMEOUT_EN
          else if (tmo_done) begin
            rd_req   <= 1'b0;
            state_q  <= ST_ERROR;
            pwr_on   <= 1'b0;
            wake_err <= 1'b1;
          end
`endif
        end
        ST_ISO_REL: begin
          isolation <= 1'b1;
          state_q   <= ST_RST_REL;
        end
        ST_RST_REL: begin
          if (settle_done) begin
            reset_assert <= 1'b0;
            state_q      <= ST_CLK_EN;
          end
        end
        ST_CLK_EN: begin
          clk_gate  <= 1'b0;
          wake_done <= 1'b1;
          state_q   <= ST_RUN;
        end
        ST_ERROR: begin
          pwr_on       <= 1'b0;
          isolation    <= 1'b0;
          reset_assert <= 1'b1;
          clk_gate     <= 1'b1;
          wake_err     <= 1'b1;
          if (!wake_req) begin
            state_q  <= ST_SLEEP;
            wake_err <= 1'b0;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_s3_wake_sequencer.sv
// Scoreboard bench for s3_wake_sequencer: expected state-change events are queued by
// the stimulus and checked by an independent monitor on every {state, wake_done} change.
module tb_s3_wake_sequencer;
  import s3_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sleep_entered = 1'b0;
  logic       wake_req = 1'b0;
  logic       pwr_good = 1'b0;
  logic       rd_ack = 1'b0;
  logic [3:0] rd_data = '0;
  logic       rd_req;
  logic [1:0] rd_addr;
  logic [3:0] restored_result, restored_a, restored_b;
  logic [1:0] restored_opcode;
  logic       pwr_on, isolation, reset_assert, clk_gate, wake_done, wake_err;
  logic [2:0] state;

  always #5 clk = ~clk;

  s3_wake_sequencer #(.PWR_SETTLE(4), .RST_HOLD(2), .PG_TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .sleep_entered   (sleep_entered),
    .wake_req        (wake_req),
    .pwr_good        (pwr_good),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ack          (rd_ack),
    .rd_data         (rd_data),
    .restored_result (restored_result),
    .restored_a      (restored_a),
    .restored_b      (restored_b),
    .restored_opcode (restored_opcode),
    .pwr_on          (pwr_on),
    .isolation       (isolation),
    .reset_assert    (reset_assert),
    .clk_gate        (clk_gate),
    .wake_done       (wake_done),
    .wake_err        (wake_err),
    .state           (state)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic        pw, iso, rst, gate, done, err, req;
    logic [1:0]  addr;
    logic [3:0]  r, a, b;
    logic [1:0]  op;
  } ev_t;

  ev_t         q[$];
  string       nq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected-output model, updated by the stimulus before each push.
  logic       m_pw = 1'b1, m_iso = 1'b1, m_rst = 1'b0, m_gate = 1'b0;
  logic       m_done = 1'b0, m_err = 1'b0, m_req = 1'b0;
  logic [1:0] m_addr = '0, m_op = '0;
  logic [3:0] m_r = '0, m_a = '0, m_b = '0;

  logic [3:0] mem [4];
  bit         ack_en = 1'b1;

  // Retention RAM: acks on the second cycle each word is presented.
  initial begin : ram
    logic [1:0] la;
    bit         lr;
    int         wc;
    la = '0; lr = 1'b0; wc = 0;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        if (lr && la == rd_addr) wc++;
        else wc = 0;
      end else begin
        wc = 0;
      end
      rd_ack  = ack_en && (rd_req === 1'b1) && (wc == 1);
      rd_data = (rd_req === 1'b1) ? mem[rd_addr] : '0;
      la = rd_addr;
      lr = (rd_req === 1'b1);
    end
  end

  initial begin : monitor
    logic [3:0] prev;
    bit         first;
    ev_t        act, e;
    string      nm;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && (first || {state, wake_done} != prev)) begin
        first = 1'b0;
        act = '{cyc: cyc, st: state, pw: pwr_on, iso: isolation, rst: reset_assert,
                gate: clk_gate, done: wake_done, err: wake_err, req: rd_req, addr: rd_addr,
                r: restored_result, a: restored_a, b: restored_b, op: restored_opcode};
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got %h (state %0d at cycle %0d), required no event",
                   act, state, cyc);
        end else begin
          e  = q.pop_front();
          nm = nq.pop_front();
          if (act !== e)
            begin
              n_bad++;
              $display("FAIL %s: got %h (state %0d cyc %0d) required %h (state %0d cyc %0d)",
                       nm, act, act.st, act.cyc, e, e.st, e.cyc);
            end
        end
      end
      prev = {state, wake_done};
    end
  end

  task automatic ev(input string nm, input int unsigned c, input logic [2:0] s);
    q.push_back('{cyc: c, st: s, pw: m_pw, iso: m_iso, rst: m_rst, gate: m_gate,
                  done: m_done, err: m_err, req: m_req, addr: m_addr,
                  r: m_r, a: m_a, b: m_b, op: m_op});
    nq.push_back(nm);
  endtask

  task automatic model_reset();
    m_pw = 1'b1; m_iso = 1'b1; m_rst = 1'b0; m_gate = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_req = 1'b0; m_addr = '0;
    m_r = '0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  // base = cycle at which RESTORE is entered; ack lands on the 2nd cycle of each word.
  task automatic tail(input int unsigned base);
    logic [3:0] w3;
    w3 = mem[3];
    m_req = 1'b0; m_addr = 2'd3;
    m_r = mem[0]; m_a = mem[1]; m_b = mem[2]; m_op = w3[1:0];
    ev("iso_rel", base + 8, 3'd4);
    m_iso = 1'b1;
    ev("rst_rel", base + 9, 3'd5);
    m_rst = 1'b0;
    ev("clk_en", base + 11, 3'd6);
    m_gate = 1'b0; m_done = 1'b1;
    ev("wake_done", base + 12, 3'd0);
    m_done = 1'b0;
    ev("done_fall", base + 13, 3'd0);
  endtask

  task automatic go_sleep();
    sleep_entered = 1'b1;
    m_pw = 1'b0; m_iso = 1'b0; m_rst = 1'b1; m_gate = 1'b1;
    ev("sleep", cyc + 1, 3'd1);
    @(negedge clk);
    sleep_entered = 1'b0;
  endtask

  task automatic wake(output int unsigned e0);
    e0 = cyc + 1;
    wake_req = 1'b1;
    m_pw = 1'b1;
    ev("pwr_up", e0, 3'd2);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d events outstanding, required 0 (next %s)",
               q.size(), nq[0]);
      q.delete();
      nq.delete();
    end
  endtask

  initial begin : stim
    int unsigned e0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    ev("reset_state", cyc + 1, 3'd0);
    @(negedge clk);

    // wake_req in RUN must not create any event
    wake_req = 1'b1;
    repeat (2) @(negedge clk);
    wake_req = 1'b0;
    drain();

    // Nominal wake: 17 cycles from wake_req sample to wake_done
    mem[0] = 4'd9; mem[1] = 4'd3; mem[2] = 4'd6; mem[3] = 4'd2;
    go_sleep();
    wake(e0);
    pwr_good = 1'b1;
    m_req = 1'b1; m_addr = 2'd0;
    ev("restore", e0 + 5, 3'd3);
    @(negedge clk);
    wake_req = 1'b0;
    tail(e0 + 5);
    drain();

    // pwr_good glitch after three good cycles restarts settling
    mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'hC; mem[3] = 4'h1;
    go_sleep();
    wake(e0);
    pwr_good = 1'b1;
    m_req = 1'b1; m_addr = 2'd0;
    ev("restore_after_glitch", e0 + 9, 3'd3);
    @(negedge clk);
    wake_req = 1'b0;
    repeat (3) @(negedge clk);
    pwr_good = 1'b0;
    @(negedge clk);
    pwr_good = 1'b1;
    tail(e0 + 9);
    drain();

    // Rail never good: ERROR after the timeout, exit to SLEEP on wake_req low
    go_sleep();
    pwr_good = 1'b0;
    wake(e0);
    m_pw = 1'b0; m_err = 1'b1;
    ev("pg_timeout_error", e0 + 17, 3'd7);
    repeat (20) @(negedge clk);
    wake_req = 1'b0;
    m_err = 1'b0;
    ev("error_exit", e0 + 20, 3'd1);
    drain();

    // Reset while rd_addr=2 aborts to reset values and clears restored context
    mem[0] = 4'h7; mem[1] = 4'hB; mem[2] = 4'h4; mem[3] = 4'h1;
    pwr_good = 1'b1;
    wake(e0);
    m_req = 1'b1; m_addr = 2'd0;
    ev("restore_pre_reset", e0 + 5, 3'd3);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    wake_req = 1'b0;
    model_reset();
    ev("reset_abort", e0 + 10, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drain();

`ifdef RESTORE_TIMEOUT_EN
    // rd_ack withheld: ERROR 16 cycles after rd_req rises
    go_sleep();
    ack_en = 1'b0;
    wake(e0);
    m_req = 1'b1; m_addr = 2'd0;
    ev("restore_no_ack", e0 + 5, 3'd3);
    m_req = 1'b0; m_pw = 1'b0; m_err = 1'b1;
    ev("ack_timeout_error", e0 + 21, 3'd7);
    repeat (23) @(negedge clk);
    wake_req = 1'b0;
    m_err = 1'b0;
    ev("ack_error_exit", e0 + 23, 3'd1);
    drain();
    ack_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
